mem_arbiter: RTL and testbench

- Two-port arbiter and sequencer for the single synchronous program/data BRAM.
- Port 0 serves the SLC-3 control/datapath (MAR/MDR side). Port 1 serves the program loader / debug requester.
- Hides the BRAM's registered-output read latency behind a req/gnt/done handshake, so neither requester counts wait states itself.
- Ties between the ports are resolved round-robin.

---
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter/sequencer for the single program/data BRAM
// Hides the BRAM registered-read latency behind a req/gnt/done handshake.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  input  logic [DATA_W-1:0] bram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

  state_t            state, state_nxt;
  logic              winner;
  logic              rr_last;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [2:0]        cnt;
  logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;
  logic              pick_valid;
  logic              pick;

  // On a tie the port that did not win last time is chosen.
  assign pick_valid = m0_req | m1_req;
  assign pick       = m1_req & (~m0_req | ~rr_last);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    m0_done   = 1'b0;
    m1_done   = 1'b0;
    bram_en   = 1'b0;
    bram_we   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        bram_en   = 1'b1;
        bram_we   = lat_we;
        m0_gnt    = ~winner;
        m1_gnt    = winner;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == 3'd1) state_nxt = DONE;
      end
      DONE: begin
        m0_done   = ~winner;
        m1_done   = winner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      winner     <= 1'b0;
      rr_last    <= 1'b1;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      cnt        <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      if (state == IDLE && pick_valid) begin
        winner  <= pick;
        rr_last <= pick;
        if (pick) begin
          lat_we    <= m1_we;
          lat_addr  <= m1_addr;
          lat_wdata <= m1_wdata;
        end else begin
          lat_we    <= m0_we;
          lat_addr  <= m0_addr;
          lat_wdata <= m0_wdata;
        end
      end
      if (state == ISSUE)     cnt <= RD_LAT_C;
      else if (state == WAIT) cnt <= cnt - 3'd1;
      // Last WAIT cycle: the BRAM output register now holds the read word.
      if (state == WAIT && cnt == 3'd1 && !lat_we) begin
        if (winner) m1_rdata_q <= bram_rdata;
        else        m0_rdata_q <= bram_rdata;
      end
    end
  end

  assign bram_addr  = lat_addr;
  assign bram_wdata = lat_wdata;
  assign m0_rdata   = m0_rdata_q;
  assign m1_rdata   = m1_rdata_q;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
// Includes a 2-cycle-latency BRAM model with a preload port.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_done, m1_gnt, m1_done;
  logic [15:0] m0_rdata, m1_rdata;
  logic        bram_en, bram_we, busy;
  logic [15:0] bram_addr, bram_wdata, bram_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(2)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata), .busy(busy)
  );

  // BRAM: sync read plus output register, 2 cycles from enable edge
  logic [15:0] mem [0:65535];
  logic [15:0] r1 = 16'h0, r2 = 16'h0;
  logic        pl_en = 1'b0;
  logic [15:0] pl_addr = 16'h0, pl_data = 16'h0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_wdata;
      r1 <= mem[bram_addr];
    end
    r2 <= r1;
  end
  assign bram_rdata = r2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick;
    pl_en = 1'b0;
  endtask

  // One solo access from IDLE; checks gnt at cycle 1, done at cycle 4, IDLE at 5.
  task automatic do_access(input int p, input logic we, input logic [15:0] addr,
                           input logic [15:0] wd, input logic [15:0] exp_rd, input string tag);
    logic [4:0] dmask;
    int         wecnt;
    logic       lose;
    dmask = '0; wecnt = 0; lose = 1'b0;
    if (p == 0) begin m0_req = 1; m0_we = we; m0_addr = addr; m0_wdata = wd; end
    else        begin m1_req = 1; m1_we = we; m1_addr = addr; m1_wdata = wd; end
    tick;
    chk({tag, "_gnt"}, (p == 0) ? m0_gnt : m1_gnt, 1);
    chk({tag, "_en"}, bram_en, 1);
    chk({tag, "_addr"}, bram_addr, addr);
    chk({tag, "_wdata"}, bram_wdata, wd);
    m0_req = 0; m1_req = 0;
    m0_addr = 16'hFFFF; m1_addr = 16'hFFFF; m0_wdata = 16'h5555; m1_wdata = 16'h5555;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) tick;
      wecnt += int'(bram_we);
      dmask[c] = (p == 0) ? m0_done : m1_done;
      lose |= (p == 0) ? (m1_gnt | m1_done) : (m0_gnt | m0_done);
    end
    chk({tag, "_done_at4"}, dmask, 5'b10000);
    chk({tag, "_rdata"}, (p == 0) ? m0_rdata : m1_rdata, exp_rd);
    chk({tag, "_we_cycles"}, wecnt, int'(we));
    chk({tag, "_loser_quiet"}, lose, 0);
    tick;
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    logic [19:0] g0, g1, d0, d1, en;
    logic        dsum;
    logic [15:0] exp_b2b [0:2];
    int          k;
    exp_b2b[0] = 16'h1111; exp_b2b[1] = 16'h2222; exp_b2b[2] = 16'h3333;

    reset = 1; m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
    m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
    tick;
    preload(16'h3000, 16'h1234);
    preload(16'h0020, 16'hA0A0);
    preload(16'h0030, 16'hB0B0);
    preload(16'h0000, 16'h1111);
    preload(16'h0001, 16'h2222);
    preload(16'h0002, 16'h3333);

    chk("rst_ctl", {busy, m0_gnt, m1_gnt, m0_done, m1_done, bram_en, bram_we}, 0);
    chk("rst_addr", bram_addr, 0);
    chk("rst_wdata", bram_wdata, 0);
    chk("rst_rd0", m0_rdata, 0);
    chk("rst_rd1", m1_rdata, 0);
    reset = 0;

    do_access(0, 1'b0, 16'h3000, 16'h0000, 16'h1234, "rd0");
    chk("rd0_m1_rdata_held", m1_rdata, 0);
    do_access(1, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, "wr1");
    do_access(1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, "rb1");
    chk("rb1_m0_rdata_held", m0_rdata, 16'h1234);

    // Late competitor arrives during port 0 WAIT
    g1 = '0; d0 = '0; d1 = '0; en = '0;
    m0_req = 1; m0_we = 0; m0_addr = 16'h3000;
    for (int c = 1; c <= 9; c++) begin
      tick;
      if (c == 1) m0_req = 0;
      if (c == 2) begin m1_req = 1; m1_we = 0; m1_addr = 16'h0010; end
      en[c] = bram_en; g1[c] = m1_gnt; d0[c] = m0_done; d1[c] = m1_done;
      if (m1_gnt) m1_req = 0;
      if (m1_done) chk("late_m1_rdata", m1_rdata, 16'hBEEF);
    end
    chk("late_en", en, 20'h00042);
    chk("late_m1_gnt", g1, 20'h00040);
    chk("late_m0_done", d0, 20'h00010);
    chk("late_m1_done", d1, 20'h00200);
    m1_req = 0;
    tick;

    // Tie from reset: 0,1,0,1 every 5 cycles
    reset = 1;
    m0_req = 1; m1_req = 1; m0_we = 0; m1_we = 0; m0_addr = 16'h0020; m1_addr = 16'h0030;
    tick;
    reset = 0;
    g0 = '0; g1 = '0; d0 = '0; d1 = '0;
    for (int c = 1; c <= 20; c++) begin
      tick;
      g0[c] = m0_gnt; g1[c] = m1_gnt; d0[c] = m0_done; d1[c] = m1_done;
      if (m0_done) chk("tie_m0_rdata", m0_rdata, 16'hA0A0);
      if (m1_done) chk("tie_m1_rdata", m1_rdata, 16'hB0B0);
    end
    m0_req = 0; m1_req = 0;
    chk("tie_g0", g0, 20'h00802);
    chk("tie_g1", g1, 20'h10040);
    chk("tie_d0", d0, 20'h04010);
    chk("tie_d1", d1, 20'h80200);

    // Back-to-back port 0 reads with req held
    reset = 1; tick; reset = 0;
    m0_req = 1; m0_addr = 16'h0000; g0 = '0; k = 0;
    for (int c = 1; c <= 15; c++) begin
      tick;
      g0[c] = m0_gnt;
      if (m0_gnt) m0_addr = m0_addr + 16'd1;
      if (m0_done) begin
        chk("b2b_rdata", m0_rdata, (k < 3) ? exp_b2b[k] : 16'hDEAD);
        k++;
      end
    end
    m0_req = 0;
    chk("b2b_gnts", g0, 20'h00842);
    chk("b2b_ndone", k, 3);

    // Reset in first WAIT cycle of a port 0 read
    reset = 1; tick; reset = 0;
    m0_req = 1; m0_addr = 16'h3000;
    tick;
    m0_req = 0;
    tick;
    reset = 1;
    tick;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rd0", m0_rdata, 0);
    reset = 0;
    dsum = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick;
      dsum |= m0_done;
    end
    chk("mid_rst_no_done", dsum, 0);
    m0_req = 1; m1_req = 1; m0_addr = 16'h0020; m1_addr = 16'h0030;
    tick;
    chk("mid_rst_rr_g0", m0_gnt, 1);
    chk("mid_rst_rr_g1", m1_gnt, 0);
    m0_req = 0; m1_req = 0;
    for (int c = 0; c < 5; c++) tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
